// File: rtl/sys1_input_ctrl_if.sv
// Player/system input bundle between the hps_io side and the System 1 core.
// Carries PS/2 key events, the two joystick words, cabinet mode and the active-low INP bytes.
interface sys1_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystk1;
  logic [15:0] joystk2;
  logic        cabinet;
  logic [7:0]  INP0;
  logic [7:0]  INP1;
  logic [7:0]  INP2;

  modport master (
    output ps2_key,
    output joystk1,
    output joystk2,
    output cabinet,
    input  INP0,
    input  INP1,
    input  INP2
  );

  modport slave (
    input  ps2_key,
    input  joystk1,
    input  joystk2,
    input  cabinet,
    output INP0,
    output INP1,
    output INP2
  );
endinterface

// File: rtl/sys1_input_ctrl.sv
// Merges PS/2 keys and joysticks into the System 1 INP0/1/2 bytes and shapes each
// coin request into one fixed-length, vblank-timed pulse.
//
// state     | meaning
// ST_IDLE   | coin inactive, waiting for a request rising edge
// ST_ACTIVE | coin asserted, counting COIN_FRAMES frame ticks
// ST_GAP    | coin forced inactive, counting COIN_GAP frame ticks
module sys1_input_ctrl #(
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             vblank,
  sys1_input_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } coin_st_e;

  localparam int K_L    = 0;
  localparam int K_R    = 1;
  localparam int K_T1   = 2;
  localparam int K_T2   = 3;
  localparam int K_S1   = 4;
  localparam int K_S2   = 5;
  localparam int K_C1   = 6;
  localparam int K_C2   = 7;
  localparam int K_F1   = 8;
  localparam int K_F2   = 9;
  localparam int K_P2L  = 10;
  localparam int K_P2R  = 11;
  localparam int K_P2T1 = 12;
  localparam int K_P2T2 = 13;
  localparam int NKEYS  = 14;

  localparam logic [3:0] FRAMES_LAST = 4'(COIN_FRAMES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(COIN_GAP - 1);

  logic [NKEYS-1:0]     keys_q, keys_d;
  logic                 ps2_tog_q, ps2_tog_d;
  logic [SYNC_STAGES:0] vb_sync_q, vb_sync_d;
  logic                 tick;

  coin_st_e             st_q [2];
  coin_st_e             st_d [2];
  logic [3:0]           cnt_q [2];
  logic [3:0]           cnt_d [2];
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           req_q, req_d;
  logic [1:0]           req, rise, coin_on;

  logic [7:0]           inp0_q, inp0_d;
  logic [7:0]           inp1_q, inp1_d;
  logic [7:0]           inp2_q, inp2_d;

  logic p2_l, p2_r, p2_t1, p2_t2;
  logic p1_l, p1_r, p1_t1, p1_t2;
  logic start1, start2;
  logic pressed;

  assign pressed = io.ps2_key[9];

  // A PS/2 event is any change of the toggle strobe against its registered copy.
  always_comb begin
    keys_d    = keys_q;
    ps2_tog_d = io.ps2_key[10];
    if (io.ps2_key[10] != ps2_tog_q) begin
      if (io.ps2_key[7:0] == 8'h6B) begin
        keys_d[K_L] = pressed;
      end else if (io.ps2_key[7:0] == 8'h74) begin
        keys_d[K_R] = pressed;
      end else begin
        case (io.ps2_key[8:0])
          9'h029:  keys_d[K_T1]   = pressed;
          9'h014:  keys_d[K_T2]   = pressed;
          9'h005:  keys_d[K_F1]   = pressed;
          9'h006:  keys_d[K_F2]   = pressed;
          9'h016:  keys_d[K_S1]   = pressed;
          9'h01E:  keys_d[K_S2]   = pressed;
          9'h02E:  keys_d[K_C1]   = pressed;
          9'h036:  keys_d[K_C2]   = pressed;
          9'h023:  keys_d[K_P2L]  = pressed;
          9'h034:  keys_d[K_P2R]  = pressed;
          9'h01C:  keys_d[K_P2T1] = pressed;
          9'h01B:  keys_d[K_P2T2] = pressed;
          default: ;
        endcase
      end
    end
  end

  // The top stage is only the edge-detect delay; the rest is the synchroniser chain.
  always_comb begin
    vb_sync_d = {vb_sync_q[SYNC_STAGES-1:0], vblank};
    tick      = vb_sync_q[SYNC_STAGES-1] & ~vb_sync_q[SYNC_STAGES];
  end

  always_comb begin
    p2_l   = keys_q[K_P2L]  | io.joystk2[1];
    p2_r   = keys_q[K_P2R]  | io.joystk2[0];
    p2_t1  = keys_q[K_P2T1] | io.joystk2[4];
    p2_t2  = keys_q[K_P2T2] | io.joystk2[5];
    p1_l   = keys_q[K_L]  | io.joystk1[1] | (~io.cabinet & p2_l);
    p1_r   = keys_q[K_R]  | io.joystk1[0] | (~io.cabinet & p2_r);
    p1_t1  = keys_q[K_T1] | io.joystk1[4] | (~io.cabinet & p2_t1);
    p1_t2  = keys_q[K_T2] | io.joystk1[5] | (~io.cabinet & p2_t2);
    start1 = keys_q[K_S1] | keys_q[K_F1] | io.joystk1[6] | io.joystk2[6];
    start2 = keys_q[K_S2] | keys_q[K_F2] | io.joystk1[7] | io.joystk2[7];
    req[0] = keys_q[K_C1] | keys_q[K_F1] | io.joystk1[8];
    req[1] = keys_q[K_C2] | keys_q[K_F2] | io.joystk2[8];
    rise   = req & ~req_q;
    req_d  = req;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      pend_d[i] = pend_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            st_d[i]  = ST_ACTIVE;
            cnt_d[i] = 4'd0;
          end
        end
        ST_ACTIVE: begin
          if (rise[i]) pend_d[i] = 1'b1;
          if (tick) begin
            if (cnt_q[i] == FRAMES_LAST) begin
              cnt_d[i] = 4'd0;
              if (COIN_GAP != 0) begin
                st_d[i] = ST_GAP;
              end else if (pend_d[i]) begin
                st_d[i]   = ST_ACTIVE;
                pend_d[i] = 1'b0;
              end else begin
                st_d[i] = ST_IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (rise[i]) pend_d[i] = 1'b1;
          if (tick) begin
            if (cnt_q[i] == GAP_LAST) begin
              cnt_d[i] = 4'd0;
              if (pend_d[i]) begin
                st_d[i]   = ST_ACTIVE;
                pend_d[i] = 1'b0;
              end else begin
                st_d[i] = ST_IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
        end
        default: begin
          st_d[i]   = ST_IDLE;
          cnt_d[i]  = 4'd0;
          pend_d[i] = 1'b0;
        end
      endcase
      coin_on[i] = (st_q[i] == ST_ACTIVE);
    end
  end

  always_comb begin
    inp0_d = ~{p1_l, p1_r, 3'b000, p1_t2, p1_t1, 1'b0};
    inp1_d = ~{p2_l, p2_r, 3'b000, p2_t2, p2_t1, 1'b0};
    inp2_d = ~{2'b00, start2, start1, 3'b000, coin_on[0] | coin_on[1]};
  end

  // The toggle copy tracks through reset so releasing reset never fakes a key event.
  always_ff @(posedge clk_sys) begin
    ps2_tog_q <= ps2_tog_d;
    if (reset) begin
      keys_q    <= '0;
      vb_sync_q <= '0;
      pend_q    <= '0;
      req_q     <= '0;
      inp0_q    <= 8'hFF;
      inp1_q    <= 8'hFF;
      inp2_q    <= 8'hFF;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= 4'd0;
      end
    end else begin
      keys_q    <= keys_d;
      vb_sync_q <= vb_sync_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      inp0_q    <= inp0_d;
      inp1_q    <= inp1_d;
      inp2_q    <= inp2_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.INP0 = inp0_q;
  assign io.INP1 = inp1_q;
  assign io.INP2 = inp2_q;

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Directed bench for sys1_input_ctrl: key/joystick merging, cabinet modes and coin pulse shaping.
module tb_sys1_input_ctrl;
  logic clk_sys = 1'b0;
  logic reset;
  logic vblank = 1'b0;

  int checks   = 0;
  int failures = 0;

  int fcnt       = 0;
  int runs       = 0;
  int rises_low  = 0;
  int hr         = 99;
  int last_gap   = -1;
  logic coin_prev = 1'b0;
  logic tog      = 1'b0;

  int s_runs, s_low;

  sys1_input_ctrl_if bus ();

  sys1_input_ctrl #(
    .COIN_FRAMES(3),
    .COIN_GAP(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .vblank(vblank),
    .io(bus)
  );

  always #5 clk_sys = ~clk_sys;

  // 16-cycle frames with vblank high for 4; counts frame rises seen while coin is low.
  always @(negedge clk_sys) begin
    logic vb_new;
    logic coin_now;
    fcnt   = (fcnt == 15) ? 0 : fcnt + 1;
    vb_new = (fcnt < 4);
    if (vb_new && !vblank) begin
      if (bus.INP2[0] == 1'b0) rises_low = rises_low + 1;
      else hr = hr + 1;
    end
    coin_now = ~bus.INP2[0];
    if (coin_now && !coin_prev) begin
      runs     = runs + 1;
      last_gap = hr;
      hr       = 0;
    end
    coin_prev = coin_now;
    vblank    = vb_new;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ps2(input logic prs, input logic [8:0] code, input logic do_toggle);
    if (do_toggle) tog = ~tog;
    bus.ps2_key = {tog, prs, code};
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic mid_frame();
    while (fcnt != 8) @(negedge clk_sys);
  endtask

  task automatic coin_press();
    bus.joystk1[8] = 1'b1;
    cyc(2);
    bus.joystk1[8] = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.ps2_key = 11'h7FF;
    bus.joystk1 = 16'hFFFF;
    bus.joystk2 = 16'hFFFF;
    bus.cabinet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("rst_hold", {8'h0, bus.INP0, bus.INP1, bus.INP2}, 32'h00FFFFFF);
    end
    reset       = 1'b0;
    bus.ps2_key = 11'h000;
    bus.joystk1 = 16'h0;
    bus.joystk2 = 16'h0;
    cyc(1);
    chk("rst_release", {8'h0, bus.INP0, bus.INP1, bus.INP2}, 32'h00FFFFFF);
    cyc(3);
    chk("idle", {8'h0, bus.INP0, bus.INP1, bus.INP2}, 32'h00FFFFFF);

    ps2(1'b1, 9'h029, 1'b1);
    cyc(1);
    chk("ps2_latency", {24'h0, bus.INP0}, 32'hFF);
    cyc(1);
    chk("ps2_trig1", {24'h0, bus.INP0}, 32'hFD);
    ps2(1'b0, 9'h029, 1'b0);
    cyc(3);
    chk("ps2_norepeat", {24'h0, bus.INP0}, 32'hFD);
    ps2(1'b0, 9'h029, 1'b1);
    cyc(2);
    chk("ps2_release", {24'h0, bus.INP0}, 32'hFF);

    ps2(1'b1, 9'h16B, 1'b1);
    cyc(2);
    chk("ps2_e0_left", {24'h0, bus.INP0}, 32'h7F);
    ps2(1'b0, 9'h16B, 1'b1);
    cyc(2);
    chk("ps2_left_rel", {24'h0, bus.INP0}, 32'hFF);

    ps2(1'b1, 9'h01B, 1'b1);
    cyc(2);
    chk("ps2_p2_trig2", {16'h0, bus.INP0, bus.INP1}, 32'hFFFB);
    ps2(1'b0, 9'h01B, 1'b1);
    cyc(2);

    bus.cabinet    = 1'b0;
    bus.joystk2[1] = 1'b1;
    cyc(1);
    chk("upright_p2l", {16'h0, bus.INP0, bus.INP1}, 32'h7F7F);
    bus.cabinet = 1'b1;
    cyc(1);
    chk("cocktail_p2l", {16'h0, bus.INP0, bus.INP1}, 32'hFF7F);
    bus.joystk2 = 16'h0;
    bus.joystk1[7] = 1'b1;
    cyc(1);
    chk("start2_j1", {24'h0, bus.INP2}, 32'hDF);
    bus.joystk1 = 16'h0;
    bus.joystk2[6] = 1'b1;
    cyc(1);
    chk("start1_j2", {24'h0, bus.INP2}, 32'hEF);
    bus.joystk2 = 16'h0;
    cyc(2);

    ps2(1'b1, 9'h005, 1'b1);
    cyc(4);
    chk("f1_start_coin", {24'h0, bus.INP2}, 32'hEE);
    ps2(1'b0, 9'h005, 1'b1);
    cyc(3);
    chk("f1_coin_holds", {24'h0, bus.INP2}, 32'hFE);
    cyc(112);
    chk("f1_done", {24'h0, bus.INP2}, 32'hFF);

    mid_frame();
    s_runs = runs;
    s_low  = rises_low;
    bus.joystk1[8] = 1'b1;
    cyc(160);
    chk("hold_runs", 32'(runs - s_runs), 32'd1);
    chk("hold_frames", 32'(rises_low - s_low), 32'd3);
    bus.joystk1[8] = 1'b0;
    cyc(96);
    chk("hold_release", 32'(runs - s_runs), 32'd1);

    mid_frame();
    s_runs = runs;
    s_low  = rises_low;
    coin_press();
    cyc(14);
    coin_press();
    cyc(6);
    coin_press();
    cyc(300);
    chk("pend_runs", 32'(runs - s_runs), 32'd2);
    chk("pend_frames", 32'(rises_low - s_low), 32'd6);
    chk("pend_gap", 32'(last_gap), 32'd2);

    mid_frame();
    coin_press();
    cyc(14);
    coin_press();
    cyc(4);
    chk("coin_active", {24'h0, bus.INP2}, 32'hFE);
    reset = 1'b1;
    cyc(1);
    chk("rst_abort", {24'h0, bus.INP2}, 32'hFF);
    reset  = 1'b0;
    s_runs = runs;
    cyc(192);
    chk("no_replay", 32'(runs - s_runs), 32'd0);
    chk("after_rst", {24'h0, bus.INP2}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
